// File: rtl/dual_fetch_stage.sv
// Dual-lane fetch stage: owns the PC, fetches 8-byte aligned instruction pairs,
// and presents them to decode through a valid/ready IF/ID register.
module dual_fetch_stage #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          MEM_WORDS    = 64,
   parameter bit          LANE2_ENABLE = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr1,
   input  logic [31:0] imem_instr2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr0,
   output logic [31:0] out_instr1,
   output logic [1:0]  out_lane_valid,
   output logic        fetch_done,
   output logic [31:0] fetched_count
);

   localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

   logic [31:0] pc_q, pc_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic [31:0] out_instr0_q, out_instr0_d;
   logic [31:0] out_instr1_q, out_instr1_d;
   logic [1:0]  lane_valid_q, lane_valid_d;
   logic        fetch_done_q, fetch_done_d;
   logic [31:0] count_q, count_d;

   logic accept;
   logic advance;
   logic unused_bits;

   assign imem_addr = {pc_q[31:3], 3'b000};
   assign out_valid = |lane_valid_q;
   assign accept    = out_valid & out_ready;
   assign advance   = ~out_valid | out_ready;

   // Low PC bits only matter through the alignment of imem_addr and lane 0 kill.
   assign unused_bits = ^{redirect_target[1:0], pc_q[1:0]};

   always_comb begin
      pc_d         = pc_q;
      out_pc_d     = out_pc_q;
      out_instr0_d = out_instr0_q;
      out_instr1_d = out_instr1_q;
      lane_valid_d = lane_valid_q;
      fetch_done_d = fetch_done_q;
      count_d      = count_q;

      // A pair accepted in the same cycle as a redirect is still retired.
      if (accept) begin
         count_d = count_q + {31'd0, lane_valid_q[0]} + {31'd0, lane_valid_q[1]};
      end

      if (redirect_valid) begin
         pc_d         = {redirect_target[31:2], 2'b00};
         lane_valid_d = 2'b00;
         fetch_done_d = 1'b0;
      end else if (advance) begin
         if (!fetch_done_q && (imem_addr < MEM_BYTES)) begin
            out_instr0_d    = imem_instr1;
            out_instr1_d    = imem_instr2;
            out_pc_d        = imem_addr;
            lane_valid_d[0] = ~pc_q[2];
            lane_valid_d[1] = LANE2_ENABLE;
            pc_d            = imem_addr + 32'd8;
         end else begin
            lane_valid_d = 2'b00;
            fetch_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q         <= RESET_PC;
         out_pc_q     <= 32'd0;
         out_instr0_q <= 32'd0;
         out_instr1_q <= 32'd0;
         lane_valid_q <= 2'b00;
         fetch_done_q <= 1'b0;
         count_q      <= 32'd0;
      end else begin
         pc_q         <= pc_d;
         out_pc_q     <= out_pc_d;
         out_instr0_q <= out_instr0_d;
         out_instr1_q <= out_instr1_d;
         lane_valid_q <= lane_valid_d;
         fetch_done_q <= fetch_done_d;
         count_q      <= count_d;
      end
   end

   assign out_pc         = out_pc_q;
   assign out_instr0     = out_instr0_q;
   assign out_instr1     = out_instr1_q;
   assign out_lane_valid = lane_valid_q;
   assign fetch_done     = fetch_done_q;
   assign fetched_count  = count_q;

endmodule

// File: tb/tb_dual_fetch_stage.sv
// Bench for dual_fetch_stage: one instance with lane 1 disabled, one with it
// enabled, driven in lockstep; accepted pairs are matched against a queue.
module tb_dual_fetch_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [1:0]  lanes;
   } pair_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        out_ready;

   logic [31:0] addr0, addr1, pc0, pc1, i00, i01, i10, i11, cnt0, cnt1;
   logic        v0, v1, done0, done1;
   logic [1:0]  lv0, lv1;

   int errors = 0;
   int checks = 0;
   pair_t q0[$];
   pair_t q1[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   dual_fetch_stage #(.RESET_PC(32'h0), .MEM_WORDS(64), .LANE2_ENABLE(1'b0)) u0 (
      .clk(clk), .reset(reset), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .imem_addr(addr0),
      .imem_instr1(mem_word(addr0)), .imem_instr2(mem_word(addr0 + 32'd4)),
      .out_valid(v0), .out_ready(out_ready), .out_pc(pc0), .out_instr0(i00),
      .out_instr1(i01), .out_lane_valid(lv0), .fetch_done(done0),
      .fetched_count(cnt0));

   dual_fetch_stage #(.RESET_PC(32'h0), .MEM_WORDS(64), .LANE2_ENABLE(1'b1)) u1 (
      .clk(clk), .reset(reset), .redirect_valid(redirect_valid),
      .redirect_target(redirect_target), .imem_addr(addr1),
      .imem_instr1(mem_word(addr1)), .imem_instr2(mem_word(addr1 + 32'd4)),
      .out_valid(v1), .out_ready(out_ready), .out_pc(pc1), .out_instr0(i10),
      .out_instr1(i11), .out_lane_valid(lv1), .fetch_done(done1),
      .fetched_count(cnt1));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_pair(input string tag, input pair_t e, input logic [31:0] pc,
                             input logic [31:0] in0, input logic [31:0] in1,
                             input logic [1:0] lv);
      check({tag, "_pc"}, pc, e.pc);
      check({tag, "_lanes"}, {30'd0, lv}, {30'd0, e.lanes});
      check({tag, "_instr0"}, in0, mem_word(e.pc));
      check({tag, "_instr1"}, in1, mem_word(e.pc + 32'd4));
   endtask

   // Scoreboard: every accepted pair must be the next expected one.
   always @(negedge clk) begin
      pair_t e;
      if (!reset) begin
         if (v0 && out_ready) begin
            if (q0.size() == 0) check("u0_unexpected_pc", pc0, 32'hFFFF_FFFF);
            else begin
               e = q0.pop_front();
               check_pair("u0_acc", e, pc0, i00, i01, lv0);
            end
         end
         if (v1 && out_ready) begin
            if (q1.size() == 0) check("u1_unexpected_pc", pc1, 32'hFFFF_FFFF);
            else begin
               e = q1.pop_front();
               check_pair("u1_acc", e, pc1, i10, i11, lv1);
            end
         end
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_both(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) begin
         q0.push_back('{pc: start + 32'(8 * i), lanes: 2'b01});
         q1.push_back('{pc: start + 32'(8 * i), lanes: 2'b11});
      end
   endtask

   task automatic check_counts(input string tag, input logic [31:0] e0, input logic [31:0] e1);
      check({tag, "_cnt0"}, cnt0, e0);
      check({tag, "_cnt1"}, cnt1, e1);
   endtask

   initial begin
      reset = 1'b1; redirect_valid = 1'b0; redirect_target = 32'h0; out_ready = 1'b0;
      step(2);
      check("rst_valid", {31'd0, v0}, 32'd0);
      check("rst_lanes", {30'd0, lv1}, 32'd0);
      check("rst_addr", addr0, 32'h0);
      check("rst_done", {31'd0, done1}, 32'd0);
      check_counts("rst", 32'd0, 32'd0);

      // Streaming from reset: four pairs accepted back to back.
      reset = 1'b0; out_ready = 1'b1;
      push_both(32'h0, 4);
      step(1);
      check("first_out_pc", pc0, 32'h0);
      check("first_addr", addr0, 32'h8);
      check("first_lanes0", {30'd0, lv0}, 32'd1);
      check("first_lanes1", {30'd0, lv1}, 32'd3);
      step(4);
      check_counts("stream", 32'd4, 32'd8);
      check("stream_pc", pc0, 32'h20);

      // Stall with a valid pair held.
      out_ready = 1'b0;
      step(3);
      check("stall_pc", pc0, 32'h20);
      check("stall_addr", addr1, 32'h28);
      check("stall_instr0", i10, mem_word(32'h20));
      check_counts("stall", 32'd4, 32'd8);
      push_both(32'h20, 1);
      out_ready = 1'b1;
      step(1);
      check("release_pc", pc1, 32'h28);
      check_counts("release", 32'd5, 32'd10);

      // Redirect while a pair is held and not accepted: pair is dropped.
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h18;
      step(1);
      redirect_valid = 1'b0; out_ready = 1'b1;
      check("redir_valid", {31'd0, v0}, 32'd0);
      check("redir_addr", addr0, 32'h18);
      check_counts("redir", 32'd5, 32'd10);
      push_both(32'h18, 1);
      step(1);
      check("redir_tgt_pc", pc0, 32'h18);
      check("redir_tgt_lanes0", {30'd0, lv0}, 32'd1);

      // Misaligned redirect coinciding with an accept.
      redirect_valid = 1'b1; redirect_target = 32'h1F;
      step(1);
      redirect_valid = 1'b0;
      check("mis_valid", {31'd0, v1}, 32'd0);
      check("mis_addr", addr1, 32'h18);
      check_counts("mis_acc", 32'd6, 32'd12);
      q1.push_back('{pc: 32'h18, lanes: 2'b10});
      push_both(32'h20, 28);
      step(1);
      check("mis_pc1", pc1, 32'h18);
      check("mis_lanes1", {30'd0, lv1}, 32'd2);
      check("mis_valid0", {31'd0, v0}, 32'd0);
      step(1);
      check("mis_next_pc", pc0, 32'h20);
      check("mis_next_lanes1", {30'd0, lv1}, 32'd3);

      // Run off the end of memory.
      step(27);
      check("end_pc", pc1, 32'hF8);
      check("end_addr", addr0, 32'h100);
      check("end_done_pre", {31'd0, done0}, 32'd0);
      step(1);
      check("end_done0", {31'd0, done0}, 32'd1);
      check("end_done1", {31'd0, done1}, 32'd1);
      check("end_valid", {31'd0, v1}, 32'd0);
      step(2);
      check("end_hold_done", {31'd0, done0}, 32'd1);
      check("end_hold_valid", {31'd0, v0}, 32'd0);
      check("end_hold_addr", addr1, 32'h100);
      check_counts("end", 32'd34, 32'd69);

      // Redirect clears fetch_done and resumes.
      redirect_valid = 1'b1; redirect_target = 32'h18;
      step(1);
      redirect_valid = 1'b0;
      check("resume_done", {31'd0, done1}, 32'd0);
      check("resume_addr", addr0, 32'h18);
      push_both(32'h18, 1);
      step(2);
      check("resume_pc", pc0, 32'h20);
      check_counts("resume", 32'd35, 32'd71);

      // Reset mid-run wins over a simultaneous redirect.
      reset = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
      step(1);
      check("mid_rst_addr", addr0, 32'h0);
      check("mid_rst_pc", pc1, 32'h0);
      check("mid_rst_instr0", i10, 32'h0);
      check("mid_rst_instr1", i11, 32'h0);
      check("mid_rst_lanes", {30'd0, lv1}, 32'd0);
      check("mid_rst_done", {31'd0, done0}, 32'd0);
      check_counts("mid_rst", 32'd0, 32'd0);
      reset = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;
      step(1);
      check("q0_left", 32'(q0.size()), 32'd0);
      check("q1_left", 32'(q1.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
